// File: rtl/univ_shift_pkg.sv
// Shared types and helpers for the universal shift register.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // True for the operations that may be repeated by a counted burst.
    function automatic logic is_shift(input mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

endpackage : univ_shift_pkg

// File: rtl/univ_shift_reg_step.sv
// Combinational next-value function for one register step.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    input  mode_t            op_i,
    output logic [WIDTH-1:0] q_next_o
);

    // Select the next register value for the requested operation.
    always_comb begin
        q_next_o = q_i;
        case (op_i)
            HOLD:    q_next_o = q_i;
            LOAD:    q_next_o = d_i;
            SHL:     q_next_o = {q_i[WIDTH-2:0], sin_i};
            SHR:     q_next_o = {sin_i, q_i[WIDTH-1:1]};
            ROL:     q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            ROR:     q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            ASR:     q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            CLR:     q_next_o = '0;
            default: q_next_o = q_i;
        endcase
    end

endmodule : shift_step

// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted burst mode and busy/done handshake.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             res,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    mode_t            burst_op_q, burst_op_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    mode_t            mode_in;
    mode_t            op_sel;
    logic [CW-1:0]    count_cl;
    logic [WIDTH-1:0] q_step;

    assign mode_in = mode_t'(mode);

    // Counts above WIDTH are only representable when WIDTH+1 is not a power of 2.
    assign count_cl = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;

    // Burst steps use the latched op; otherwise the live mode drives the step.
    assign op_sel = (state_q == BURST) ? burst_op_q : mode_in;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q_i     (q_q),
        .d_i     (D),
        .sin_i   (sin),
        .op_i    (op_sel),
        .q_next_o(q_step)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        burst_op_d  = burst_op_q;
        remaining_d = remaining_q;
        q_d         = q_step;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (count_cl != '0) && is_shift(mode_in)) begin
                    burst_op_d  = mode_in;
                    remaining_d = count_cl;
                    q_d         = q_q;
                    busy_d      = 1'b1;
                    state_d     = BURST;
                end
            end
            BURST: begin
                remaining_d = remaining_q - CW'(1);
                if (remaining_q == CW'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge CLK or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            burst_op_q  <= HOLD;
            remaining_q <= '0;
            q_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_op_q  <= burst_op_d;
            remaining_q <= remaining_d;
            q_q         <= q_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             res;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             start;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q;
    logic             sout_l, sout_r, busy, done;

    int vectors = 0;
    int errors  = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .res   (res),
        .mode  (mode),
        .D     (d),
        .sin   (sin),
        .start (start),
        .count (count),
        .Q     (q),
        .sout_l(sout_l),
        .sout_r(sout_r),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] m, input logic [7:0] dv, input logic s);
        mode = m; d = dv; sin = s; start = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic saw_done;
        res = 1'b1; mode = HOLD; d = '0; sin = 1'b0; start = 1'b0; count = '0;
        step(); step();
        chk("reset_q",    32'(q),    32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        res = 1'b0;

        // Single operations
        do_op(LOAD, 8'hB4, 1'b0); chk("load_b4", 32'(q), 32'hB4);
        do_op(SHL,  8'h00, 1'b1); chk("shl_69",  32'(q), 32'h69);
        do_op(SHR,  8'h00, 1'b0); chk("shr_34",  32'(q), 32'h34);
        do_op(LOAD, 8'h81, 1'b0);
        do_op(ROL,  8'h00, 1'b0); chk("rol_03",  32'(q), 32'h03);
        do_op(LOAD, 8'h80, 1'b0);
        do_op(ASR,  8'h00, 1'b0); chk("asr_c0",  32'(q), 32'hC0);
        chk("sout_l_c0", 32'(sout_l), 32'h1);
        chk("sout_r_c0", 32'(sout_r), 32'h0);
        do_op(CLR,  8'h00, 1'b0); chk("clr_00",  32'(q), 32'h00);
        do_op(LOAD, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_op(HOLD, 8'hFF, 1'b1); chk("hold_3c", 32'(q), 32'h3C);
        end

        // Asynchronous reset between edges
        do_op(LOAD, 8'hA5, 1'b0); chk("pre_rst_a5", 32'(q), 32'hA5);
        mode = HOLD;
        #2 res = 1'b1;
        #1;
        chk("async_rst_q",    32'(q),    32'h00);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        #1 res = 1'b0;

        // Basic ROL burst, count 3
        do_op(LOAD, 8'h01, 1'b0);
        mode = ROL; start = 1'b1; count = CW'(3);
        step();
        chk("b1_start_q",    32'(q),    32'h01);
        chk("b1_start_busy", 32'(busy), 32'h1);
        mode = HOLD; start = 1'b0;
        step(); chk("b1_s1_q", 32'(q), 32'h02); chk("b1_s1_busy", 32'(busy), 32'h1);
        step(); chk("b1_s2_q", 32'(q), 32'h04); chk("b1_s2_busy", 32'(busy), 32'h1);
        step(); chk("b1_s3_q", 32'(q), 32'h08); chk("b1_s3_busy", 32'(busy), 32'h0);
        chk("b1_s3_done", 32'(done), 32'h1);
        step(); chk("b1_after_done", 32'(done), 32'h0); chk("b1_after_q", 32'(q), 32'h08);

        // ROR burst ignores mode/D/start changes
        do_op(LOAD, 8'hF0, 1'b0);
        mode = ROR; start = 1'b1; count = CW'(4);
        step(); chk("b2_start_q", 32'(q), 32'hF0);
        mode = LOAD; d = 8'hFF; start = 1'b1; count = CW'(2);
        step(); chk("b2_s1_q", 32'(q), 32'h78);
        step(); step();
        step(); chk("b2_final_q", 32'(q), 32'h0F); chk("b2_done", 32'(done), 32'h1);
        mode = HOLD; start = 1'b0;

        // start with count 0 executes mode normally
        do_op(LOAD, 8'h11, 1'b0);
        mode = SHL; sin = 1'b0; start = 1'b1; count = '0;
        step(); chk("c0_q", 32'(q), 32'h22); chk("c0_busy", 32'(busy), 32'h0);
        mode = HOLD; start = 1'b0;
        step(); chk("c0_busy2", 32'(busy), 32'h0); chk("c0_done", 32'(done), 32'h0);

        // ROL burst with count = WIDTH
        do_op(LOAD, 8'h5A, 1'b0);
        mode = ROL; start = 1'b1; count = CW'(8);
        step(); mode = HOLD; start = 1'b0;
        step(); chk("b8_s1_q", 32'(q), 32'hB4);
        for (int i = 2; i < 8; i++) begin
            step(); chk("b8_busy", 32'(busy), 32'h1);
        end
        step(); chk("b8_q", 32'(q), 32'h5A); chk("b8_done", 32'(done), 32'h1);
        chk("b8_busy_end", 32'(busy), 32'h0);

        // Out-of-range count is clamped to WIDTH
        mode = ROL; start = 1'b1; count = CW'(15);
        step(); mode = HOLD; start = 1'b0;
        for (int i = 1; i < 8; i++) step();
        chk("clamp_busy7", 32'(busy), 32'h1);
        step(); chk("clamp_done", 32'(done), 32'h1); chk("clamp_q", 32'(q), 32'h5A);
        step();

        // Reset mid-burst
        do_op(LOAD, 8'hFF, 1'b0);
        mode = SHL; sin = 1'b0; start = 1'b1; count = CW'(6);
        step(); mode = HOLD; start = 1'b0;
        step(); step(); chk("mid_q_fc", 32'(q), 32'hFC);
        #2 res = 1'b1;
        #1;
        chk("mid_rst_q",    32'(q),    32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step();
        res = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_no_done", 32'(saw_done), 32'h0);
        do_op(LOAD, 8'h01, 1'b0);
        mode = ROR; start = 1'b1; count = CW'(1);
        step(); chk("post_busy", 32'(busy), 32'h1);
        mode = HOLD; start = 1'b0;
        step(); chk("post_q", 32'(q), 32'h80); chk("post_done", 32'(done), 32'h1);

        // Back-to-back burst accepted in the done cycle
        do_op(LOAD, 8'h01, 1'b0);
        mode = SHL; sin = 1'b0; start = 1'b1; count = CW'(2);
        step(); start = 1'b0; mode = HOLD;
        step(); chk("bb_s1_q", 32'(q), 32'h02);
        step(); chk("bb_s2_q", 32'(q), 32'h04); chk("bb_done", 32'(done), 32'h1);
        mode = SHL; start = 1'b1; count = CW'(1);
        step(); chk("bb_rebusy", 32'(busy), 32'h1); chk("bb_hold_q", 32'(q), 32'h04);
        chk("bb_done_clr", 32'(done), 32'h0);
        mode = HOLD; start = 1'b0;
        step(); chk("bb2_q", 32'(q), 32'h08); chk("bb2_done", 32'(done), 32'h1);
        chk("bb2_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg
